// File: rtl/gray_pkg.sv
// Shared constants and helpers for the parametrised Gray-code counter.
// Functions take a zero-extended vector of up to GRAY_MAX_W bits.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB; zero bits above the real width do not disturb the result.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        logic                  acc;
        acc = 1'b0;
        b   = '0;
        for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter_param_gray2bin_conv.sv
// Combinational Gray-to-binary converter of generic width (prefix XOR from the MSB).
module gray2bin_conv #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    logic acc;

    always_comb begin
        acc = 1'b0;
        bin = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
    end

endmodule

// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray-code counter with load, sticky wrap flags and binary output.
// Define GRAY_COUNTER_SATURATE_EN to hold at the limits instead of wrapping around.
module gray_counter_param
    import gray_pkg::*;
#(
    parameter int               WIDTH      = 3,
    parameter logic [WIDTH-1:0] RESET_CODE = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Dir,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadCode,
    input  logic             ClrFlags,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Binary,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] BIN_MAX = '1;
    localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1);

    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] reset_bin;
    logic             ovf;
    logic             ovf_nxt;
    logic             unf;
    logic             unf_nxt;
    logic             wrap;
    logic             wrap_nxt;

    gray2bin_conv #(.WIDTH(WIDTH)) u_load_conv (
        .gray (LoadCode),
        .bin  (load_bin)
    );

    gray2bin_conv #(.WIDTH(WIDTH)) u_reset_conv (
        .gray (RESET_CODE),
        .bin  (reset_bin)
    );

    // A wrap in the same cycle as ClrFlags re-sets its own flag after the clear.
    always_comb begin
        bin_nxt  = bin;
        wrap_nxt = 1'b0;
        ovf_nxt  = ClrFlags ? 1'b0 : ovf;
        unf_nxt  = ClrFlags ? 1'b0 : unf;
        if (Load) begin
            bin_nxt = load_bin;
        end else if (En) begin
            case (Dir)
                DIR_UP: begin
                    if (bin == BIN_MAX) begin
                        ovf_nxt  = 1'b1;
                        wrap_nxt = 1'b1;
`ifdef GRAY_COUNTER_SATURATE_EN
                        bin_nxt  = bin;
`else
                        bin_nxt  = '0;
`endif
                    end else begin
                        bin_nxt = bin + BIN_ONE;
                    end
                end
                DIR_DOWN: begin
                    if (bin == '0) begin
                        unf_nxt  = 1'b1;
                        wrap_nxt = 1'b1;
`ifdef GRAY_COUNTER_SATURATE_EN
                        bin_nxt  = bin;
`else
                        bin_nxt  = BIN_MAX;
`endif
                    end else begin
                        bin_nxt = bin - BIN_ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bin  <= reset_bin;
            ovf  <= 1'b0;
            unf  <= 1'b0;
            wrap <= 1'b0;
        end else begin
            bin  <= bin_nxt;
            ovf  <= ovf_nxt;
            unf  <= unf_nxt;
            wrap <= wrap_nxt;
        end
    end

    assign Binary    = bin;
    assign Output    = bin ^ (bin >> 1);
    assign Overflow  = ovf;
    assign Underflow = unf;
    assign Wrap      = wrap;

endmodule
